// File: rtl/axi_dma_cmd_scheduler.sv
// Purpose : sequences a 256-bit axi_dma engine for mem-to-mem copies; queues copy
//           descriptors, splits each into <=MAX_CHUNK read/write command pairs, reports completion.
// Latency : pop->first init 2 cycles; after the last pair is accepted, done comes IDLE_GUARD+1
//           cycles later at the earliest (the guard, then both idles high, then DONE).
// Backpressure: desc_ready low while the queue is full. Each init is held until its own
//           ready is seen; the next chunk waits for both. There is no timeout on the idle wait.
// Ports   : desc_* (descriptor push, valid/ready), axi_read_start_* / init_read and
//           axi_write_start_* / init_write (DMA command handshakes), axi_dma_*_idle (engine
//           status), done_* (one-cycle completion pulse), busy, queue_count.
module axi_dma_cmd_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_CHUNK  = 4096,
  parameter int DESC_DEPTH = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int IDLE_GUARD = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic [ADDR_WIDTH-1:0]         desc_src_addr,
  input  logic [ADDR_WIDTH-1:0]         desc_dst_addr,
  input  logic [31:0]                   desc_len,
  input  logic [TAG_WIDTH-1:0]          desc_tag,
  output logic [ADDR_WIDTH-1:0]         axi_read_start_addr,
  output logic [31:0]                   axi_read_length,
  output logic                          init_read,
  input  logic                          axi_read_start_ready,
  output logic [ADDR_WIDTH-1:0]         axi_write_start_addr,
  output logic [31:0]                   axi_write_length,
  output logic                          init_write,
  input  logic                          axi_write_start_ready,
  input  logic                          axi_dma_rd_idle,
  input  logic                          axi_dma_wr_idle,
  output logic                          done_valid,
  output logic [TAG_WIDTH-1:0]          done_tag,
  output logic                          done_err,
  output logic                          busy,
  output logic [$clog2(DESC_DEPTH):0]   queue_count
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int LSB_W      = $clog2(BEAT_BYTES);
  localparam int PTR_W      = $clog2(DESC_DEPTH);
  localparam int CNT_W      = $clog2(DESC_DEPTH) + 1;
  localparam int GRD_W      = (IDLE_GUARD > 0) ? $clog2(IDLE_GUARD + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Descriptor queue storage (no reset needed: entries are only read when counted valid)
  logic [ADDR_WIDTH-1:0] q_src [DESC_DEPTH];
  logic [ADDR_WIDTH-1:0] q_dst [DESC_DEPTH];
  logic [31:0]           q_len [DESC_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag [DESC_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  // Descriptor in flight
  logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
  logic [31:0]           cur_rem;
  logic [TAG_WIDTH-1:0]  cur_tag;
  logic                  cur_err;
  logic                  rd_acc, wr_acc;
  logic [GRD_W-1:0]      guard;

  logic        push, pop;
  logic [31:0] chunk;
  logic        len_bad;
  logic        chunk_done;

  assign desc_ready = (queue_count != CNT_W'(DESC_DEPTH));
  assign push       = desc_valid & desc_ready;
  assign pop        = (state == S_IDLE) & (queue_count != '0);
  assign busy       = (state != S_IDLE) | (queue_count != '0);

  assign chunk   = (cur_rem > 32'(MAX_CHUNK)) ? 32'(MAX_CHUNK) : cur_rem;
  // In LOAD cur_rem still holds the full descriptor length.
  assign len_bad = (cur_rem == 32'd0) | (|cur_rem[LSB_W-1:0]);
  // A side counts as accepted if it already was, or its ready is high at this edge.
  assign chunk_done = (state == S_ISSUE)
                    & (rd_acc | axi_read_start_ready)
                    & (wr_acc | axi_write_start_ready);

  assign axi_read_start_addr  = cur_src;
  assign axi_write_start_addr = cur_dst;
  assign axi_read_length      = chunk;
  assign axi_write_length     = chunk;

  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr] <= desc_src_addr;
      q_dst[wr_ptr] <= desc_dst_addr;
      q_len[wr_ptr] <= desc_len;
      q_tag[wr_ptr] <= desc_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    init_read  = 1'b0;
    init_write = 1'b0;
    done_valid = 1'b0;
    done_tag   = '0;
    done_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (queue_count != '0) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = len_bad ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        init_read  = ~rd_acc;
        init_write = ~wr_acc;
        if (chunk_done) state_nxt = (cur_rem == chunk) ? S_WAIT_IDLE : S_ISSUE;
      end
      S_WAIT_IDLE: begin
        if ((guard == '0) && axi_dma_rd_idle && axi_dma_wr_idle) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_tag   = cur_tag;
        done_err   = cur_err;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_src <= '0;
      cur_dst <= '0;
      cur_rem <= '0;
      cur_tag <= '0;
      cur_err <= 1'b0;
      rd_acc  <= 1'b0;
      wr_acc  <= 1'b0;
      guard   <= '0;
    end else begin
      // Head entry is captured on the pop edge so LOAD can judge its length.
      if (pop) begin
        cur_src <= q_src[rd_ptr];
        cur_dst <= q_dst[rd_ptr];
        cur_rem <= q_len[rd_ptr];
        cur_tag <= q_tag[rd_ptr];
        cur_err <= 1'b0;
      end
      if (state == S_LOAD) begin
        cur_err <= len_bad;
        rd_acc  <= 1'b0;
        wr_acc  <= 1'b0;
      end
      if (state == S_ISSUE) begin
        if (chunk_done) begin
          cur_src <= cur_src + ADDR_WIDTH'(chunk);
          cur_dst <= cur_dst + ADDR_WIDTH'(chunk);
          cur_rem <= cur_rem - chunk;
          rd_acc  <= 1'b0;
          wr_acc  <= 1'b0;
          if (cur_rem == chunk) guard <= GRD_W'(IDLE_GUARD);
        end else begin
          if (axi_read_start_ready)  rd_acc <= 1'b1;
          if (axi_write_start_ready) wr_acc <= 1'b1;
        end
      end
      if ((state == S_WAIT_IDLE) && (guard != '0)) guard <= guard - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_dma_cmd_scheduler.sv
// Purpose : self-checking bench for axi_dma_cmd_scheduler against a descriptor-level model.
// Latency : n/a (bench).
// Backpressure: command readies and idles are driven per mode (tied, stalled, delayed, random).
module tb_axi_dma_cmd_scheduler;

  localparam int IDLE_GUARD = 4;
  localparam int MAXC       = 4096;

  typedef struct packed { logic [63:0] addr; logic [31:0] len; } cmd_t;
  typedef struct packed { logic [3:0] tag; logic err; } done_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [63:0] desc_src_addr = '0, desc_dst_addr = '0;
  logic [31:0] desc_len = '0;
  logic [3:0]  desc_tag = '0;
  logic [63:0] axi_read_start_addr, axi_write_start_addr;
  logic [31:0] axi_read_length, axi_write_length;
  logic        init_read, init_write;
  logic        axi_read_start_ready = 1'b0, axi_write_start_ready = 1'b0;
  logic        axi_dma_rd_idle = 1'b0, axi_dma_wr_idle = 1'b0;
  logic        done_valid, done_err, busy;
  logic [3:0]  done_tag;
  logic [2:0]  queue_count;

  always #5 clk = ~clk;

  axi_dma_cmd_scheduler dut (
    .clk(clk), .rstn(rstn),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr),
    .desc_len(desc_len), .desc_tag(desc_tag),
    .axi_read_start_addr(axi_read_start_addr), .axi_read_length(axi_read_length),
    .init_read(init_read), .axi_read_start_ready(axi_read_start_ready),
    .axi_write_start_addr(axi_write_start_addr), .axi_write_length(axi_write_length),
    .init_write(init_write), .axi_write_start_ready(axi_write_start_ready),
    .axi_dma_rd_idle(axi_dma_rd_idle), .axi_dma_wr_idle(axi_dma_wr_idle),
    .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
    .busy(busy), .queue_count(queue_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model output and observed traffic
  cmd_t  exp_rd[$], exp_wr[$], obs_rd[$], obs_wr[$];
  done_t exp_done[$], obs_done[$];
  int    lat_q[$], rd_age_q[$], wr_age_q[$];

  // Monitor state
  int   cyc = 0, rd_hi = 0, wr_hi = 0, n_rd = 0, n_wr = 0, last_acc = 0;
  int   stab_err = 0, init_seen = 0;
  logic rd_hold = 1'b0, wr_hold = 1'b0;
  cmd_t prev_rd, prev_wr;

  // 0: readies high, 1: readies low, 2: read ready after 5 cycles / write immediate, 3: random
  int rdy_mode = 0;
  // 0: idles high, 1: idles low, 3: random
  int idle_mode = 0;

  task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic monitor_step();
    cmd_t c;
    cyc++;
    if (!rstn) begin
      rd_hi = 0; wr_hi = 0; n_rd = 0; n_wr = 0; rd_hold = 1'b0; wr_hold = 1'b0;
    end else begin
      if (init_read || init_write) init_seen++;
      if (init_read) begin
        c = '{addr: axi_read_start_addr, len: axi_read_length};
        rd_hi++;
        if (rd_hold && c != prev_rd) stab_err++;
        prev_rd = c;
        if (axi_read_start_ready) begin
          obs_rd.push_back(c); rd_age_q.push_back(rd_hi);
          rd_hi = 0; n_rd++; last_acc = cyc; rd_hold = 1'b0;
        end else rd_hold = 1'b1;
      end else rd_hold = 1'b0;
      if (init_write) begin
        c = '{addr: axi_write_start_addr, len: axi_write_length};
        wr_hi++;
        if (wr_hold && c != prev_wr) stab_err++;
        prev_wr = c;
        if (axi_write_start_ready) begin
          obs_wr.push_back(c); wr_age_q.push_back(wr_hi);
          wr_hi = 0; n_wr++; last_acc = cyc; wr_hold = 1'b0;
        end else wr_hold = 1'b1;
      end else wr_hold = 1'b0;
      // One side may never run a whole chunk ahead of the other.
      if (n_rd - n_wr > 1 || n_wr - n_rd > 1) stab_err++;
      if (done_valid) begin
        obs_done.push_back('{tag: done_tag, err: done_err});
        if (!done_err) lat_q.push_back(cyc - last_acc);
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin axi_read_start_ready = 1'b1; axi_write_start_ready = 1'b1; end
      1: begin axi_read_start_ready = 1'b0; axi_write_start_ready = 1'b0; end
      2: begin axi_read_start_ready = (rd_hi >= 4); axi_write_start_ready = 1'b1; end
      default: begin
        axi_read_start_ready  = ($urandom_range(0, 3) != 0);
        axi_write_start_ready = ($urandom_range(0, 3) != 0);
      end
    endcase
    case (idle_mode)
      0: begin axi_dma_rd_idle = 1'b1; axi_dma_wr_idle = 1'b1; end
      1: begin axi_dma_rd_idle = 1'b0; axi_dma_wr_idle = 1'b0; end
      default: begin
        axi_dma_rd_idle = ($urandom_range(0, 1) == 1);
        axi_dma_wr_idle = ($urandom_range(0, 1) == 1);
      end
    endcase
  end

  // Descriptor-level model: a good descriptor becomes ceil(len/MAXC) command pairs.
  task automatic model_push(input logic [63:0] s, input logic [63:0] d,
                            input logic [31:0] l, input logic [3:0] t);
    done_t dd;
    logic [31:0] rem, c;
    logic [63:0] off;
    dd.tag = t;
    dd.err = (l == 0) || (l % 32 != 0);
    if (!dd.err) begin
      rem = l; off = 0;
      while (rem > 0) begin
        c = (rem > MAXC) ? MAXC : rem;
        exp_rd.push_back('{addr: s + off, len: c});
        exp_wr.push_back('{addr: d + off, len: c});
        off = off + 64'(c);
        rem = rem - c;
      end
    end
    exp_done.push_back(dd);
  endtask

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic push(input logic [63:0] s, input logic [63:0] d,
                      input logic [31:0] l, input logic [3:0] t);
    int n = 0;
    desc_src_addr = s; desc_dst_addr = d; desc_len = l; desc_tag = t; desc_valid = 1'b1;
    @(negedge clk);
    while (!desc_ready && n < 3000) begin @(negedge clk); n++; end
    chk("push_ready", desc_ready, 1'b1);
    if (desc_ready) model_push(s, d, l, t);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    desc_src_addr = $urandom; desc_len = $urandom;  // only sampled on push
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin @(negedge clk); n++; end
    chk("drain_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic compare_all();
    chk("rd_cmd_count", obs_rd.size(), exp_rd.size());
    chk("wr_cmd_count", obs_wr.size(), exp_wr.size());
    chk("done_count", obs_done.size(), exp_done.size());
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) chk("rd_cmd", obs_rd[i], exp_rd[i]);
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) chk("wr_cmd", obs_wr[i], exp_wr[i]);
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++) chk("done", obs_done[i], exp_done[i]);
    chk("cmd_stability", stab_err, 0);
    obs_rd.delete(); obs_wr.delete(); obs_done.delete();
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    stab_err = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_desc_ready", desc_ready, 1'b1);
    chk("rst_init_read", init_read, 1'b0);
    chk("rst_init_write", init_write, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_queue_count", queue_count, 3'd0);
    chk("rst_rd_addr", axi_read_start_addr, 64'd0);
    chk("rst_rd_len", axi_read_length, 32'd0);
    chk("rst_wr_addr", axi_write_start_addr, 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] s, d;
    logic [31:0] l;

    // Reset state
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // 1: single 256-byte copy, everything ready; done exactly after the guard
    lat_q.delete();
    push(64'h0, 64'h10000, 32'd256, 4'd3);
    wait_idle();
    chk("t1_lat_count", lat_q.size(), 1);
    // last accept cycle -> IDLE_GUARD guard cycles, one idle-sample cycle, then DONE
    if (lat_q.size() > 0) chk("t1_guard_latency", lat_q[0], IDLE_GUARD + 2);
    compare_all();

    // 2: three-chunk split (4096, 4096, 1824)
    lat_q.delete();
    push(64'h2000_0000, 64'h3000_0000, 32'h2720, 4'd5);
    wait_idle();
    chk("t2_chunks", exp_rd.size(), 3);
    if (lat_q.size() > 0) chk("t2_guard_latency", lat_q[0], IDLE_GUARD + 2);
    compare_all();

    // 3: read ready delayed 5 cycles, write immediate
    rdy_mode = 2;
    rd_age_q.delete(); wr_age_q.delete();
    push(64'h40, 64'h8000, 32'd8256, 4'd6);
    wait_idle();
    chk("t3_rd_accepts", rd_age_q.size(), 3);
    foreach (rd_age_q[i]) chk("t3_init_read_cycles", rd_age_q[i], 5);
    foreach (wr_age_q[i]) chk("t3_init_write_cycles", wr_age_q[i], 1);
    compare_all();
    rdy_mode = 0;

    // 4: rejected descriptors (zero, unaligned, 10000 bytes not beat multiple)
    init_seen = 0;
    push(64'h100, 64'h200, 32'd0, 4'd1);
    push(64'h100, 64'h200, 32'd33, 4'd2);
    push(64'h100, 64'h200, 32'd10000, 4'd7);
    wait_idle();
    chk("t4_no_init", init_seen, 0);
    compare_all();

    // 5: fill the queue while the engine stalls
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) push(64'h1000 * i, 64'h9000 + 64'h1000 * i, 32'd64, 4'(8 + i));
    chk("t5_queue_full", queue_count, 3'd4);
    chk("t5_desc_ready_low", desc_ready, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_still_full", desc_ready, 1'b0);
    chk("t5_init_held", init_read, 1'b1);
    rdy_mode = 0;
    wait_idle();
    compare_all();

    // 8: idles held low keep the descriptor from completing
    idle_mode = 1;
    push(64'h5000, 64'h6000, 32'd64, 4'd12);
    repeat (30) @(posedge clk);
    #1;
    chk("idle_low_no_done", obs_done.size(), 0);
    chk("idle_low_busy", busy, 1'b1);
    idle_mode = 0;
    wait_idle();
    compare_all();

    // 6: asynchronous reset mid-ISSUE with a second descriptor queued
    rdy_mode = 1;
    push(64'h100, 64'h200, 32'd4096, 4'd9);
    push(64'h300, 64'h400, 32'd64, 4'd10);
    n = 0;
    while (!init_read && n < 100) begin @(negedge clk); n++; end
    chk("t6_init_read_high", init_read, 1'b1);
    obs_rd.delete(); obs_wr.delete(); obs_done.delete();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rdy_mode = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_done", obs_done.size(), 0);
    chk("t6_no_cmd", obs_rd.size(), 0);
    compare_all();

    // 7: random descriptors, random readies and idles, one wrapping the address space
    rdy_mode = 3; idle_mode = 3;
    for (int i = 0; i < 12; i++) begin
      s = {$urandom, $urandom}; d = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 40);
      else l = 32 * $urandom_range(1, 400);
      if (i == 0) begin s = 64'hFFFF_FFFF_FFFF_F800; d = 64'hFFFF_FFFF_FFFF_E000; l = 32'd12288; end
      push(s, d, l, 4'($urandom));
    end
    wait_idle();
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
